// File: rtl/avmm_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// avmm_rr_arbiter_if
// Minimal Avalon-MM bundle used on both sides of the two-master arbiter.
//   address, read, write, write_data : issued by the master side
//   read_data, wait_request          : returned by the slave side
// Modports:
//   master : the side that issues transfers (drives address/read/write/data)
//   slave  : the side that services transfers (drives read_data/wait_request)
// ---------------------------------------------------------------------------
interface avmm_rr_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              wait_request;

    modport master (
        output address, read, write, write_data,
        input  read_data, wait_request
    );

    modport slave (
        input  address, read, write, write_data,
        output read_data, wait_request
    );
endinterface

// File: rtl/avmm_rr_arbiter.sv
// ---------------------------------------------------------------------------
// avmm_rr_arbiter
// Shares one Avalon-MM slave between two masters with per-transfer
// round-robin arbitration and a wait_request watchdog.
// Ports:
//   clk, rst      : clock and asynchronous active-high reset
//   m0, m1        : master-facing Avalon-MM ports (arbiter acts as slave)
//   s             : slave-facing Avalon-MM port (arbiter acts as master)
//   grant         : one-hot {m1,m0} current owner, 0 when idle
//   timeout_flag  : sticky, set when the watchdog forces a completion
// ---------------------------------------------------------------------------
module avmm_rr_arbiter #(
    parameter int                ADDR_W         = 8,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 256,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      rst,
    avmm_rr_arbiter_if.slave          m0,
    avmm_rr_arbiter_if.slave          m1,
    avmm_rr_arbiter_if.master         s,
    output logic [1:0]                grant,
    output logic                      timeout_flag
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    // One spare bit so the counter never wraps before reaching CNT_LAST.
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic               last_q, last_d;     // index of the last master served
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               force_q, force_d;   // current cycle is a forced completion
    logic               flag_q, flag_d;

    // Masters gathered into arrays so the per-master logic is written once.
    logic [1:0]         m_read, m_write, req, m_wait;
    logic [ADDR_W-1:0]  m_addr  [2];
    logic [DATA_W-1:0]  m_wdata [2];
    logic [DATA_W-1:0]  m_rdata [2];

    assign m_read     = {m1.read,  m0.read};
    assign m_write    = {m1.write, m0.write};
    assign req        = m_read | m_write;
    assign m_addr[0]  = m0.address;
    assign m_addr[1]  = m1.address;
    assign m_wdata[0] = m0.write_data;
    assign m_wdata[1] = m1.write_data;

    assign m0.wait_request = m_wait[0];
    assign m1.wait_request = m_wait[1];
    assign m0.read_data    = m_rdata[0];
    assign m1.read_data    = m_rdata[1];

    logic busy, cur, other;
    assign busy  = (state_q == BUSY0) || (state_q == BUSY1);
    assign cur   = (state_q == BUSY1);
    assign other = ~cur;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;    // m0 wins the first contended arbitration
            cnt_q   <= '0;
            force_q <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            force_q <= force_d;
            flag_q  <= flag_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        force_d = 1'b0;
        flag_d  = flag_q;
        case (state_q)
            IDLE: begin
                if (req[0] && req[1])
                    state_d = last_q ? BUSY0 : BUSY1;
                else if (req[0])
                    state_d = BUSY0;
                else if (req[1])
                    state_d = BUSY1;
            end
            BUSY0, BUSY1: begin
                if (force_q || (req[cur] && !s.wait_request)) begin
                    // Completion: hand straight to the other master if it waits.
                    last_d  = cur;
                    cnt_d   = '0;
                    state_d = req[other] ? (other ? BUSY1 : BUSY0) : IDLE;
                end else if (!req[cur]) begin
                    // Master abandoned its transfer; ownership history is kept.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        force_d = 1'b1;
                        flag_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        s.address    = '0;
        s.read       = 1'b0;
        s.write      = 1'b0;
        s.write_data = '0;
        grant        = 2'b00;
        if (busy) begin
            grant[cur]   = 1'b1;
            s.address    = m_addr[cur];
            s.write_data = m_wdata[cur];
            // Read has priority over write; a forced cycle issues nothing.
            if (!force_q) begin
                s.read  = m_read[cur];
                s.write = m_write[cur] & ~m_read[cur];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            logic sel;
            assign sel         = busy && (cur == 1'(gi));
            assign m_wait[gi]  = sel ? (force_q ? 1'b0 : s.wait_request) : 1'b1;
            assign m_rdata[gi] = !sel    ? '0 :
                                 force_q ? (m_read[gi] ? TIMEOUT_DATA : '0) :
                                           s.read_data;
        end
    endgenerate

    assign timeout_flag = flag_q;
endmodule
